pic_exec_ctrl: RTL and testbench

//  Execute-stage sequencer for the 8-bit PIC-style ALU. Accepts one 14-bit instruction per handshake from fetch.

---
 rtl/pic_pkg.sv | 60 ++++++
 rtl/pic_decode.sv | 59 +++++
 rtl/pic_exec_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_pic_exec_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared encodings for the PIC-style execute controller: codigo classes, opcodes,
// FSM states and the decoded-instruction record.
package pic_pkg;

    localparam logic [1:0] CODE_REG = 2'b00;
    localparam logic [1:0] CODE_BIT = 2'b01;
    localparam logic [1:0] CODE_ILL = 2'b10;
    localparam logic [1:0] CODE_LIT = 2'b11;

    // Byte-oriented file-register ops, control = inst[11:8]
    localparam logic [3:0] OP_MOVF   = 4'd0;
    localparam logic [3:0] OP_CLR    = 4'd1;
    localparam logic [3:0] OP_SUBWF  = 4'd2;
    localparam logic [3:0] OP_DECF   = 4'd3;
    localparam logic [3:0] OP_IORWF  = 4'd4;
    localparam logic [3:0] OP_ANDWF  = 4'd5;
    localparam logic [3:0] OP_XORWF  = 4'd6;
    localparam logic [3:0] OP_ADDWF  = 4'd7;
    localparam logic [3:0] OP_MOVWF  = 4'd8;
    localparam logic [3:0] OP_COMF   = 4'd9;
    localparam logic [3:0] OP_INCF   = 4'd10;
    localparam logic [3:0] OP_DECFSZ = 4'd11;
    localparam logic [3:0] OP_RLF    = 4'd12;
    localparam logic [3:0] OP_RRF    = 4'd13;
    localparam logic [3:0] OP_SWAPF  = 4'd14;
    localparam logic [3:0] OP_INCFSZ = 4'd15;

    // Bit ops, control = inst[13:10]
    localparam logic [3:0] OP_BCF   = 4'b0100;
    localparam logic [3:0] OP_BSF   = 4'b0101;
    localparam logic [3:0] OP_BTFSC = 4'b0110;
    localparam logic [3:0] OP_BTFSS = 4'b0111;

    // Literal ops, control = inst[11:8]; 0..7 and 11 load k into W without flags
    localparam logic [3:0] LIT_MOVLW = 4'd0;
    localparam logic [3:0] LIT_IORLW = 4'd8;
    localparam logic [3:0] LIT_ANDLW = 4'd9;
    localparam logic [3:0] LIT_XORLW = 4'd10;
    localparam logic [3:0] LIT_SUBLW = 4'd12;
    localparam logic [3:0] LIT_ADDLW = 4'd14;

    typedef enum logic [2:0] {IDLE, READ, EXEC, WB, DONE} pic_state_e;

    typedef enum logic [1:0] {SKIP_NONE, SKIP_ZERO, SKIP_BCLR, SKIP_BSET} skip_e;

    typedef struct packed {
        logic [1:0] codigo;
        logic [3:0] control;
        logic [2:0] nbit;
        logic [6:0] addr;
        logic [7:0] k;
        logic       dest_file;
        logic       wr_w;
        logic       wr_z;
        logic       wr_c;
        logic       wr_dc;
        skip_e      skip_kind;
    } dec_t;

endpackage

// File: rtl/pic_decode.sv
// Combinational instruction decoder: splits a 14-bit word into ALU controls,
// writeback destination, flag-update enables and skip kind.
module pic_decode
    import pic_pkg::*;
(
    input  logic [13:0] inst,
    output dec_t        dec
);

    always_comb begin
        dec           = '0;
        dec.codigo    = inst[13:12];
        dec.addr      = inst[6:0];
        dec.k         = inst[7:0];
        dec.skip_kind = SKIP_NONE;
        case (inst[13:12])
            CODE_REG: begin
                dec.control = inst[11:8];
                // inst == 0 is NOP: reads file 0 but writes nothing and keeps flags
                if (inst[11:0] != 12'd0) begin
                    dec.dest_file = inst[7] || (inst[11:8] == OP_MOVWF);
                    dec.wr_w      = !(inst[7] || (inst[11:8] == OP_MOVWF));
                    case (inst[11:8])
                        OP_MOVWF, OP_DECFSZ, OP_INCFSZ, OP_SWAPF: dec.wr_z = 1'b0;
                        OP_RLF, OP_RRF:     dec.wr_c = 1'b1;
                        OP_ADDWF, OP_SUBWF: begin
                            dec.wr_z  = 1'b1;
                            dec.wr_c  = 1'b1;
                            dec.wr_dc = 1'b1;
                        end
                        default:            dec.wr_z = 1'b1;
                    endcase
                    if (inst[11:8] == OP_DECFSZ || inst[11:8] == OP_INCFSZ) begin
                        dec.skip_kind = SKIP_ZERO;
                    end
                end
            end
            CODE_BIT: begin
                dec.control = inst[13:10];
                dec.nbit    = inst[9:7];
                case (inst[13:10])
                    OP_BCF, OP_BSF: dec.dest_file = 1'b1;
                    OP_BTFSC:       dec.skip_kind = SKIP_BCLR;
                    OP_BTFSS:       dec.skip_kind = SKIP_BSET;
                    default:        dec.dest_file = 1'b0;
                endcase
            end
            CODE_LIT: begin
                dec.control = inst[11:8];
                dec.wr_w    = 1'b1;
                dec.wr_z    = inst[11] && (inst[11:8] != 4'd11);
                dec.wr_c    = (inst[11:10] == 2'b11);
                dec.wr_dc   = (inst[11:10] == 2'b11);
            end
            default: dec.codigo = CODE_ILL;
        endcase
    end

endmodule

// File: rtl/pic_exec_ctrl.sv
// Execute-stage sequencer for the 8-bit PIC-style ALU: one instruction in flight,
// owns W and {DC,C,Z}, drives the external ALU and file-register port.
module pic_exec_ctrl
    import pic_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7,
    parameter int INST_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready;
    // inst_ready is high only in IDLE, and inst is ignored on every other cycle.
    input  logic              inst_valid,
    output logic              inst_ready,
    input  logic [INST_W-1:0] inst,
    output logic              fr_re,
    output logic [ADDR_W-1:0] fr_addr,
    input  logic [DATA_W-1:0] fr_rdata,
    output logic              fr_we,
    output logic [DATA_W-1:0] fr_wdata,
    output logic [1:0]        alu_codigo,
    output logic [3:0]        alu_control,
    output logic [2:0]        alu_nbit,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    input  logic              alu_dcarry,
    output logic [DATA_W-1:0] w_reg,
    output logic [2:0]        status,
    output logic              skip,
    output logic              illegal,
    output pic_state_e        dbg_state
);

    dec_t dec;

    pic_state_e        state_q, state_d;
    logic [ADDR_W-1:0] fr_addr_q, fr_addr_d;
    logic              fr_re_q, fr_re_d, fr_we_q, fr_we_d, illegal_q, illegal_d;
    logic [1:0]        alu_codigo_q, alu_codigo_d;
    logic [3:0]        alu_control_q, alu_control_d;
    logic [2:0]        alu_nbit_q, alu_nbit_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, b_q, b_d, w_q, w_d;
    logic [2:0]        status_q, status_d;
    logic              lit_q, lit_d, dest_file_q, dest_file_d, wr_w_q, wr_w_d;
    logic              wr_z_q, wr_z_d, wr_c_q, wr_c_d, wr_dc_q, wr_dc_d;
    skip_e             skip_kind_q, skip_kind_d;
    logic              skip_hit;

    pic_decode u_decode (
        .inst (inst),
        .dec  (dec)
    );

    always_comb begin
        state_d       = state_q;
        fr_addr_d     = fr_addr_q;
        fr_re_d       = 1'b0;
        fr_we_d       = 1'b0;
        illegal_d     = 1'b0;
        alu_codigo_d  = alu_codigo_q;
        alu_control_d = alu_control_q;
        alu_nbit_d    = alu_nbit_q;
        alu_a_d       = alu_a_q;
        b_d           = b_q;
        w_d           = w_q;
        status_d      = status_q;
        lit_d         = lit_q;
        dest_file_d   = dest_file_q;
        wr_w_d        = wr_w_q;
        wr_z_d        = wr_z_q;
        wr_c_d        = wr_c_q;
        wr_dc_d       = wr_dc_q;
        skip_kind_d   = skip_kind_q;
        case (state_q)
            IDLE: begin
                if (inst_valid) begin
                    if (dec.codigo == CODE_ILL) begin
                        state_d   = DONE;
                        illegal_d = 1'b1;
                    end else begin
                        fr_addr_d     = dec.addr;
                        alu_codigo_d  = dec.codigo;
                        alu_control_d = dec.control;
                        alu_nbit_d    = dec.nbit;
                        alu_a_d       = w_q;
                        lit_d         = (dec.codigo == CODE_LIT);
                        dest_file_d   = dec.dest_file;
                        wr_w_d        = dec.wr_w;
                        wr_z_d        = dec.wr_z;
                        wr_c_d        = dec.wr_c;
                        wr_dc_d       = dec.wr_dc;
                        skip_kind_d   = dec.skip_kind;
                        if (dec.codigo == CODE_LIT) begin
                            state_d = EXEC;
                            b_d     = dec.k;
                        end else begin
                            state_d = READ;
                            fr_re_d = 1'b1;
                        end
                    end
                end
            end
            READ: state_d = EXEC;
            EXEC: begin
                // The ALU samples fr_rdata on this edge; keep a copy so B stays stable in WB
                if (!lit_q) begin
                    b_d = fr_rdata;
                end
                fr_we_d = dest_file_q;
                state_d = WB;
            end
            WB: begin
                if (wr_w_q)  w_d         = alu_out;
                if (wr_z_q)  status_d[0] = alu_zero;
                if (wr_c_q)  status_d[1] = alu_carry;
                if (wr_dc_q) status_d[2] = alu_dcarry;
                state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            fr_addr_q     <= '0;
            fr_re_q       <= 1'b0;
            fr_we_q       <= 1'b0;
            illegal_q     <= 1'b0;
            alu_codigo_q  <= '0;
            alu_control_q <= '0;
            alu_nbit_q    <= '0;
            alu_a_q       <= '0;
            b_q           <= '0;
            w_q           <= '0;
            status_q      <= '0;
            lit_q         <= 1'b0;
            dest_file_q   <= 1'b0;
            wr_w_q        <= 1'b0;
            wr_z_q        <= 1'b0;
            wr_c_q        <= 1'b0;
            wr_dc_q       <= 1'b0;
            skip_kind_q   <= SKIP_NONE;
        end else begin
            state_q       <= state_d;
            fr_addr_q     <= fr_addr_d;
            fr_re_q       <= fr_re_d;
            fr_we_q       <= fr_we_d;
            illegal_q     <= illegal_d;
            alu_codigo_q  <= alu_codigo_d;
            alu_control_q <= alu_control_d;
            alu_nbit_q    <= alu_nbit_d;
            alu_a_q       <= alu_a_d;
            b_q           <= b_d;
            w_q           <= w_d;
            status_q      <= status_d;
            lit_q         <= lit_d;
            dest_file_q   <= dest_file_d;
            wr_w_q        <= wr_w_d;
            wr_z_q        <= wr_z_d;
            wr_c_q        <= wr_c_d;
            wr_dc_q       <= wr_dc_d;
            skip_kind_q   <= skip_kind_d;
        end
    end

    // Bit-test skips come from the held B copy, never from alu_out
    always_comb begin
        skip_hit = 1'b0;
        case (skip_kind_q)
            SKIP_ZERO: skip_hit = (alu_out == '0);
            SKIP_BCLR: skip_hit = !b_q[alu_nbit_q];
            SKIP_BSET: skip_hit = b_q[alu_nbit_q];
            default:   skip_hit = 1'b0;
        endcase
    end

    assign inst_ready  = (state_q == IDLE);
    assign fr_re       = fr_re_q;
    assign fr_addr     = fr_addr_q;
    assign fr_we       = fr_we_q;
    assign fr_wdata    = alu_out;
    assign alu_codigo  = alu_codigo_q;
    assign alu_control = alu_control_q;
    assign alu_nbit    = alu_nbit_q;
    assign alu_a       = alu_a_q;
    assign alu_b       = (state_q == EXEC && !lit_q) ? fr_rdata : b_q;
    assign w_reg       = w_q;
    assign status      = status_q;
    assign skip        = (state_q == WB) && skip_hit;
    assign illegal     = illegal_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pic_exec_ctrl.sv
// Bench for pic_exec_ctrl with a behavioural registered ALU, a file-register memory
// and an instruction-level reference model feeding a writeback scoreboard.
module tb_pic_exec_ctrl;
    import pic_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [13:0] inst = '0;
    logic        fr_re, fr_we;
    logic [6:0]  fr_addr;
    logic [7:0]  fr_rdata = '0;
    logic [7:0]  fr_wdata;
    logic [1:0]  alu_codigo;
    logic [3:0]  alu_control;
    logic [2:0]  alu_nbit;
    logic [7:0]  alu_a, alu_b;
    logic [7:0]  alu_out = '0;
    logic        alu_zero = 1'b0, alu_carry = 1'b0, alu_dcarry = 1'b0;
    logic [7:0]  w_reg;
    logic [2:0]  status;
    logic        skip, illegal;
    pic_state_e  dbg_state;

    logic [7:0]  fmem [128];
    logic [7:0]  mdl_mem [128];
    logic [7:0]  mdl_w = '0;
    logic [2:0]  mdl_status = '0;
    logic [16:0] exp_q [$];
    logic [16:0] mon_obs, mon_exp;
    int          n_checks = 0, n_errors = 0;
    int          re_cnt = 0, we_cnt = 0, ill_cnt = 0, skip_cnt = 0;
    logic [7:0]  saved_w;
    logic [2:0]  saved_status;

    always #5 clk = ~clk;

    pic_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .fr_re       (fr_re),
        .fr_addr     (fr_addr),
        .fr_rdata    (fr_rdata),
        .fr_we       (fr_we),
        .fr_wdata    (fr_wdata),
        .alu_codigo  (alu_codigo),
        .alu_control (alu_control),
        .alu_nbit    (alu_nbit),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .alu_dcarry  (alu_dcarry),
        .w_reg       (w_reg),
        .status      (status),
        .skip        (skip),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns {dc, c, z, result}
    function automatic logic [10:0] alu_fn(input logic [1:0] cd, input logic [3:0] ctl,
                                           input logic [2:0] nb, input logic [7:0] a,
                                           input logic [7:0] b);
        logic [8:0] s;
        logic [4:0] h;
        logic [7:0] r, m;
        logic       c, dc;
        r = b; c = 1'b0; dc = 1'b0; s = '0; h = '0;
        m = 8'd1 << nb;
        case (cd)
            2'b00: case (ctl)
                4'd0:  r = b;
                4'd1:  r = 8'd0;
                4'd2:  begin s = {1'b0, b} + {1'b0, ~a} + 9'd1; h = {1'b0, b[3:0]} + {1'b0, ~a[3:0]} + 5'd1; r = s[7:0]; c = s[8]; dc = h[4]; end
                4'd3:  r = b - 8'd1;
                4'd4:  r = a | b;
                4'd5:  r = a & b;
                4'd6:  r = a ^ b;
                4'd7:  begin s = {1'b0, a} + {1'b0, b}; h = {1'b0, a[3:0]} + {1'b0, b[3:0]}; r = s[7:0]; c = s[8]; dc = h[4]; end
                4'd8:  r = a;
                4'd9:  r = ~b;
                4'd10: r = b + 8'd1;
                4'd11: r = b - 8'd1;
                4'd12: begin r = {b[6:0], 1'b0}; c = b[7]; end
                4'd13: begin r = {1'b0, b[7:1]}; c = b[0]; end
                4'd14: r = {b[3:0], b[7:4]};
                default: r = b + 8'd1;
            endcase
            2'b01: case (ctl[1:0])
                2'd0:    r = b & ~m;
                2'd1:    r = b | m;
                default: r = b;
            endcase
            2'b11: case (ctl)
                4'd8:  r = a | b;
                4'd9:  r = a & b;
                4'd10: r = a ^ b;
                4'd12, 4'd13: begin s = {1'b0, b} + {1'b0, ~a} + 9'd1; h = {1'b0, b[3:0]} + {1'b0, ~a[3:0]} + 5'd1; r = s[7:0]; c = s[8]; dc = h[4]; end
                4'd14, 4'd15: begin s = {1'b0, a} + {1'b0, b}; h = {1'b0, a[3:0]} + {1'b0, b[3:0]}; r = s[7:0]; c = s[8]; dc = h[4]; end
                default: r = b;
            endcase
            default: r = 8'd0;
        endcase
        return {dc, c, (r == 8'd0), r};
    endfunction

    always @(posedge clk) begin
        {alu_dcarry, alu_carry, alu_zero, alu_out} <= alu_fn(alu_codigo, alu_control, alu_nbit, alu_a, alu_b);
    end

    always @(posedge clk) begin
        if (fr_re) fr_rdata <= fmem[fr_addr];
        if (fr_we) fmem[fr_addr] <= fr_wdata;
    end

    // Writeback monitor: every WB cycle is compared against the next expected record
    always @(negedge clk) begin
        if (fr_re)   re_cnt++;
        if (fr_we)   we_cnt++;
        if (illegal) ill_cnt++;
        if (skip)    skip_cnt++;
        if (rst_n && dbg_state == WB) begin
            mon_obs = {skip, fr_we, fr_we ? fr_addr : 7'd0, fr_we ? fr_wdata : 8'd0};
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'(mon_obs), 32'h1ffff);
            end else begin
                mon_exp = exp_q.pop_front();
                check_eq("wb_record", 32'(mon_obs), 32'(mon_exp));
            end
        end
    end

    task automatic model_op(input logic [13:0] ins, output int lat, output int e_re,
                            output int e_we, output int e_ill, output int e_sk);
        logic [1:0]  cd;
        logic [3:0]  ctl;
        logic [6:0]  ad;
        logic [7:0]  b;
        logic [10:0] r;
        logic        tofile, tow, sk, wz, wc, wdc;
        cd = ins[13:12]; ad = ins[6:0];
        ctl = (cd == 2'b01) ? ins[13:10] : ins[11:8];
        b = (cd == 2'b11) ? ins[7:0] : mdl_mem[ad];
        r = alu_fn(cd, ctl, ins[9:7], mdl_w, b);
        tofile = 1'b0; tow = 1'b0; sk = 1'b0; wz = 1'b0; wc = 1'b0; wdc = 1'b0;
        case (cd)
            2'b00: if (ins != 14'd0) begin
                tofile = ins[7] || (ctl == 4'd8);
                tow    = !tofile;
                wz     = !(ctl inside {4'd8, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15});
                wc     = ctl inside {4'd2, 4'd7, 4'd12, 4'd13};
                wdc    = ctl inside {4'd2, 4'd7};
                sk     = (ctl inside {4'd11, 4'd15}) && (r[7:0] == 8'd0);
            end
            2'b01: begin
                tofile = !ins[11];
                sk     = ins[11] && (b[ins[9:7]] == ins[10]);
            end
            2'b11: begin
                tow = 1'b1;
                wz  = (ctl >= 4'd8) && (ctl != 4'd11);
                wc  = (ctl >= 4'd12);
                wdc = (ctl >= 4'd12);
            end
            default: ;
        endcase
        lat   = (cd == 2'b10) ? 2 : (cd == 2'b11) ? 3 : 4;
        e_re  = (cd == 2'b00 || cd == 2'b01) ? 1 : 0;
        e_ill = (cd == 2'b10) ? 1 : 0;
        e_we  = tofile ? 1 : 0;
        e_sk  = sk ? 1 : 0;
        if (cd != 2'b10) exp_q.push_back({sk, tofile, tofile ? ad : 7'd0, tofile ? r[7:0] : 8'd0});
        if (tofile) mdl_mem[ad] = r[7:0];
        if (tow)    mdl_w = r[7:0];
        if (wz)     mdl_status[0] = r[8];
        if (wc)     mdl_status[1] = r[9];
        if (wdc)    mdl_status[2] = r[10];
    endtask

    task automatic run_op(input logic [13:0] ins);
        int lat, e_re, e_we, e_ill, e_sk, low;
        model_op(ins, lat, e_re, e_we, e_ill, e_sk);
        @(negedge clk);
        check_eq("ready_before", 32'(inst_ready), 32'd1);
        re_cnt = 0; we_cnt = 0; ill_cnt = 0; skip_cnt = 0;
        inst = ins;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst = 14'($urandom_range(0, 16383));
        low = 0;
        @(negedge clk);
        while (!inst_ready && low < 12) begin
            low++;
            @(negedge clk);
        end
        check_eq("latency", 32'(low + 1), 32'(lat));
        check_eq("fr_re_count", 32'(re_cnt), 32'(e_re));
        check_eq("fr_we_count", 32'(we_cnt), 32'(e_we));
        check_eq("illegal_count", 32'(ill_cnt), 32'(e_ill));
        check_eq("skip_count", 32'(skip_cnt), 32'(e_sk));
        check_eq("w_reg", 32'(w_reg), 32'(mdl_w));
        check_eq("status", 32'(status), 32'(mdl_status));
    endtask

    task automatic set_file(input logic [6:0] a, input logic [7:0] v);
        fmem[a] = v;
        mdl_mem[a] = v;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            fmem[i] = 8'($urandom_range(0, 255));
            mdl_mem[i] = fmem[i];
        end
        repeat (3) @(negedge clk);
        check_eq("rst_w", 32'(w_reg), 32'h0);
        check_eq("rst_status", 32'(status), 32'h0);
        check_eq("rst_strobes", 32'({fr_re, fr_we, skip, illegal}), 32'h0);
        check_eq("rst_alu", 32'({alu_codigo, alu_control, alu_nbit, alu_a, alu_b}), 32'h0);
        check_eq("rst_fr_addr", 32'(fr_addr), 32'h0);
        check_eq("rst_ready", 32'(inst_ready), 32'd1);
        rst_n = 1'b1;

        // Set every status bit, then reset in the middle of EXEC of a MOVLW
        run_op(14'h30FF);
        run_op(14'h3E01);
        check_eq("pre_rst_status", 32'(status), 32'h7);
        @(negedge clk);
        inst = 14'h3055;
        inst_valid = 1'b1;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        @(negedge clk);
        check_eq("mid_exec_state", 32'(dbg_state), 32'(EXEC));
        rst_n = 1'b0;
        #1;
        check_eq("midrst_w", 32'(w_reg), 32'h0);
        check_eq("midrst_status", 32'(status), 32'h0);
        check_eq("midrst_we", 32'(fr_we), 32'h0);
        mdl_w = '0;
        mdl_status = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("postrst_ready", 32'(inst_ready), 32'd1);
        check_eq("postrst_we", 32'(fr_we), 32'd0);
        check_eq("postrst_w", 32'(w_reg), 32'h0);

        // MOVLW 0x3C; ADDLW 0xD0
        run_op(14'h303C);
        check_eq("movlw_w", 32'(w_reg), 32'h3C);
        run_op(14'h3ED0);
        check_eq("addlw_w", 32'(w_reg), 32'h0C);
        check_eq("addlw_cz", 32'(status[1:0]), 32'b10);

        // W=5, SUBWF 0x20,1 with file 5
        set_file(7'h20, 8'h05);
        run_op(14'h3005);
        run_op(14'h02A0);
        check_eq("subwf_file", 32'(fmem[7'h20]), 32'h00);
        check_eq("subwf_z", 32'(status[0]), 32'd1);

        // DECFSZ 0x21,1 with file 1
        set_file(7'h21, 8'h01);
        saved_status = status;
        run_op(14'h0BA1);
        check_eq("decfsz_file", 32'(fmem[7'h21]), 32'h00);
        check_eq("decfsz_skip", 32'(skip_cnt), 32'd1);
        check_eq("decfsz_status", 32'(status), 32'(saved_status));

        // Bit ops on file 0x22 = 0x80
        set_file(7'h22, 8'h80);
        run_op(14'h1FA2);
        check_eq("btfss_skip", 32'(skip_cnt), 32'd1);
        check_eq("btfss_we", 32'(we_cnt), 32'd0);
        run_op(14'h1BA2);
        check_eq("btfsc_skip", 32'(skip_cnt), 32'd0);
        check_eq("btfsc_we", 32'(we_cnt), 32'd0);
        run_op(14'h1422);
        check_eq("bsf_file", 32'(fmem[7'h22]), 32'h81);

        // GOTO-class word and NOP
        run_op(14'h2ABC);
        check_eq("goto_illegal", 32'(ill_cnt), 32'd1);
        check_eq("goto_re", 32'(re_cnt), 32'd0);
        saved_w = w_reg;
        saved_status = status;
        run_op(14'h0000);
        check_eq("nop_w", 32'(w_reg), 32'(saved_w));
        check_eq("nop_status", 32'(status), 32'(saved_status));

        for (int i = 0; i < 60; i++) begin
            run_op(14'($urandom_range(0, 16383)));
        end

        repeat (2) @(negedge clk);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
